// File: rtl/spi_ram.sv
// ----------------------------------------------------------------------------
// spi_ram
//
// Single-port synchronous RAM that sits behind the SPI slave. It decodes the
// slave's 10-bit received words: bits [9:8] select the command, and the low
// bits carry the address or the data.
//
//   00 : load write address   (wr_addr <= din[ADDR_SIZE-1:0])
//   01 : write data           (mem[wr_addr] <= din[7:0])
//   10 : load read address    (rd_addr <= din[ADDR_SIZE-1:0])
//   11 : read data            (dout <= mem[rd_addr], tx_valid held high)
//
// The read result stays on dout, with tx_valid high, until the next accepted
// word of any command. An address at or above MEM_DEPTH drops a write, and
// a read from such an address returns 8'h00.
//
// Optional build macro:
//   WR_ADDR_INC_EN - after each 01 write, wr_addr advances by one and wraps
//                    to 0 from MEM_DEPTH-1. This also happens when the write
//                    is dropped as out-of-range.
//
// Ports:
//   clk      in   rising-edge clock, shared with the SPI slave
//   rst      in   synchronous active-high reset
//   din      in   [9:0] received word ([9:8] command, [7:0] payload)
//   rx_valid in   din valid this cycle (single-cycle pulse per word)
//   dout     out  [7:0] read data handed to the SPI slave
//   tx_valid out  dout valid; the SPI slave shifts dout while high
//
// state   | meaning
// --------+------------------------------------------------------
// IDLE    | no read result pending, tx_valid = 0
// RD_HOLD | read result held on dout, tx_valid = 1
// ----------------------------------------------------------------------------
module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    // One extra bit so that a depth of 2^ADDR_SIZE can be compared directly.
    localparam logic [ADDR_SIZE:0]   DEPTH = (ADDR_SIZE+1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST  = (ADDR_SIZE)'(MEM_DEPTH - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_HOLD = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [7:0]           mem [0:MEM_DEPTH-1];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [1:0]           cmd;
    logic                 wr_ok;
    logic                 rd_ok;
    logic [7:0]           rd_data;

    assign cmd   = din[9:8];
    assign wr_ok = ({1'b0, wr_addr} < DEPTH);
    assign rd_ok = ({1'b0, rd_addr} < DEPTH);

    always_comb begin
        rd_data = 8'h00;
        if (rd_ok)
            rd_data = mem[rd_addr[IDX_W-1:0]];
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM: next state and outputs
    always_comb begin
        state_nxt = state;
        tx_valid  = (state == RD_HOLD);
        if (rx_valid) begin
            if (cmd == 2'b11)
                state_nxt = RD_HOLD;
            else
                state_nxt = IDLE;
        end
    end

    // Address registers and the read-data register
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr <= '0;
            rd_addr <= '0;
            dout    <= 8'h00;
        end else if (rx_valid) begin
            case (cmd)
                2'b00: wr_addr <= din[ADDR_SIZE-1:0];
                2'b01: begin
`ifdef WR_ADDR_INC_EN
                    if (wr_addr == LAST)
                        wr_addr <= '0;
                    else
                        wr_addr <= wr_addr + (ADDR_SIZE)'(1);
`endif
                end
                2'b10: rd_addr <= din[ADDR_SIZE-1:0];
                default: dout <= rd_data;
            endcase
        end
    end

    // Memory array; contents are not reset. The rst term keeps a write from
    // landing on the same edge as a reset.
    always_ff @(posedge clk) begin
        if (!rst && rx_valid && cmd == 2'b01 && wr_ok)
            mem[wr_addr[IDX_W-1:0]] <= din[7:0];
    end

`ifndef WR_ADDR_INC_EN
    logic unused_last;
    assign unused_last = ^LAST;
`endif

endmodule
